parity_tx_ser: RTL
==================

# parity_tx_ser

Serial parity transmitter. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock, LSB first, followed by one parity bit. It is the transmitting end of the serial parity link terminated by `parity_check_ser`. A serial checker in the same parity mode sees a correct parity over every frame.

## Interface
- `WIDTH`, default 8: payload bits per frame. Legal range is 2..32.
- `PARITY_ODD`, default 0: 0 selects even parity (data plus parity has an even number of ones); 1 selects odd parity.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `din`  in  WIDTH  parallel payload; sampled only on an accepted load.
- `load`  in  1  payload valid.
- `ready`  out  1  transmitter can accept a word; combinational from state.
- `data`  out  1  serial line; registered.
- `frame`  out  1  high on every cycle `data` carries a payload or parity bit; registered.
- `par_flag`  out  1  high only on the parity-bit cycle; registered.

## Operation
- **Accept rule:** a word is accepted at a rising edge where `load && ready && rst_n`. Otherwise `load` is ignored, with no queuing.
- **States:**
  - IDLE: `ready` = 1.
  - SHIFT: `ready` = 0.
  - PARITY: `ready` = 1.
- **Transitions:**
  - IDLE → SHIFT on accept.
  - SHIFT stays in SHIFT while bit counter < WIDTH-1, then goes to PARITY.
  - PARITY → SHIFT on accept (back-to-back frame); otherwise PARITY → IDLE.
- **On accept:**
  - shift register ← `din`
  - bit counter ← 0
  - parity accumulator ← `PARITY_ODD`
- **Each SHIFT cycle:**
  - `data` ← shreg[0]
  - accumulator ^= shreg[0]
  - shreg shifts right, zero-fill
  - counter increments
- **PARITY cycle:**
  - `data` ← accumulator, which is the XOR of all WIDTH bits ^ `PARITY_ODD`
  - `par_flag` = 1
- **Idle line:** `data` = 0, `frame` = 0, `par_flag` = 0.
- **Bit counter:** width is $clog2(WIDTH). It never wraps past WIDTH-1.
- **Reset:** while `rst_n` is low at an edge, the block does all of the following, regardless of `load`:
  - state ← IDLE
  - `data`, `frame`, `par_flag` ← 0
  - counter, shreg, accumulator ← 0
- **Reset mid-frame:** the in-flight frame is abandoned with no parity bit emitted. The next accepted word starts a clean frame.
- **Load during PARITY:** the accepted word's bit 0 appears on the cycle immediately after the parity bit. There is no gap, and `frame` stays high.

## Timing
- **Frame latency:** accept at edge N gives:
  - bit k on the cycle after edge N+1+k, for k = 0..WIDTH-1
  - parity on the cycle after edge N+1+WIDTH
- **Frame length:** WIDTH+1 cycles of `frame` = 1 per word.
- **Continuous streaming:** holding `load` high sustains one word per WIDTH+1 cycles.
- **`ready` during a frame:** `ready` is low on all SHIFT cycles and high during PARITY and IDLE.
- **Output alignment:** `data`, `frame` and `par_flag` change only on rising edges and are mutually aligned.
- **After reset release:** `ready` = 1 on the first cycle with `rst_n` high. The earliest accept is that edge.

## Structure
- **Package `parity_ser_pkg`:**
  - state enum: IDLE, SHIFT, PARITY
  - constants PARITY_EVEN = 0 and PARITY_ODD = 1, shared with the checker
- **Sub-module `parity_acc`:** a running-XOR register with synchronous clear/preset and enable. The checker side reuses it.
- **Top level:** FSM, shift register and bit counter.

## Test plan
- **Even frame:** WIDTH = 8, even parity, `din` = 8'hB4 accepted once → `data` = 0,0,1,0,1,1,0,1 then parity 0; `frame` high for 9 cycles; `par_flag` high only on cycle 9; `ready` low for 8 cycles.
- **Odd-mode frame:** `PARITY_ODD` = 1, `din` = 8'hB4 → same 8 data bits, parity bit 1.
- **Back-to-back:** `load` held high with 8'h07 then 8'h01 → 18 contiguous `frame` cycles:
  - 1,1,1,0,0,0,0,0, parity 1
  - 1,0,0,0,0,0,0,0, parity 1
- **Ignored load:** `load` pulsed with 8'hFF during SHIFT of frame 8'h00 → frame 8'h00 completes with parity 0; no second frame; line idles at 0.
- **Reset mid-frame:** `rst_n` low at edge 4 of frame 8'hB4 → next cycle `data` = `frame` = `par_flag` = 0 and `ready` = 1. A following `din` = 8'h03 sends 1,1,0,0,0,0,0,0 then parity 0.
- **Loopback:** random words looped into `parity_check_ser` (same mode), 1000 frames → checker reports correct parity on every frame. Then force one `data` bit inverted → error flagged on that frame only.

Source files
------------

// File: rtl/parity_ser_pkg.sv
// Shared types and constants for the serial parity link (transmitter and checker).
package parity_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// Running-XOR register: clr loads clr_val, en folds bit_in in; clr wins over en.
// Single-cycle update, no backpressure; synchronous active-low reset clears it.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic clr_val,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  logic acc_q;
  logic acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = clr_val;
    end else if (en) begin
      acc_d = acc_q ^ bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/parity_tx_ser.sv
// Serial parity transmitter: WIDTH payload bits LSB first, then one parity bit; bit 0 one cycle
// after accept. ready drops for the SHIFT phase only, so a word loaded in PARITY follows with no gap.
module parity_tx_ser #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             data,
  output logic             frame,
  output logic             par_flag
);
  import parity_ser_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q,    state_d;
  logic [WIDTH-1:0]   shreg_q,    shreg_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               data_q,     data_d;
  logic               frame_q,    frame_d;
  logic               par_flag_q, par_flag_d;
  logic               accept;
  logic               acc;

  assign ready  = (state_q != SHIFT);
  assign accept = load && ready;

  parity_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .clr_val (PARITY_ODD),
    .en      (state_q == SHIFT),
    .bit_in  (shreg_q[0]),
    .acc     (acc)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    data_d     = 1'b0;
    frame_d    = 1'b0;
    par_flag_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        data_d  = shreg_q[0];
        frame_d = 1'b1;
        shreg_d = shreg_q >> 1;
        // Counter saturates on the last bit; the next accept reloads it.
        if (cnt_q == LAST_BIT) begin
          state_d = PARITY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        data_d     = acc;
        frame_d    = 1'b1;
        par_flag_d = 1'b1;
        state_d    = accept ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      shreg_d = din;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      data_q     <= 1'b0;
      frame_q    <= 1'b0;
      par_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      frame_q    <= frame_d;
      par_flag_q <= par_flag_d;
    end
  end

  assign data     = data_q;
  assign frame    = frame_q;
  assign par_flag = par_flag_q;

endmodule
